// File: rtl/l15_resp_pkg.sv
// l15_resp_pkg: shared request/response encodings, FSM states, capture struct and byte swap
package l15_resp_pkg;
    localparam logic [4:0] RQ_LOAD  = 5'd0;
    localparam logic [4:0] RQ_STORE = 5'd1;
    localparam logic [4:0] RQ_IMISS = 5'd16;
    localparam logic [3:0] RT_LOAD   = 4'd0;
    localparam logic [3:0] RT_IFILL  = 4'd1;
    localparam logic [3:0] RT_ST_ACK = 4'd4;
    localparam logic [3:0] RT_ERR    = 4'd15;
    localparam int unsigned ReqAddrWidth = 40;
    localparam int unsigned ReqTidWidth  = 2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_e;

    typedef struct packed {
        logic [4:0]              rqtype;
        logic [2:0]              size;
        logic [ReqAddrWidth-1:0] addr;
        logic [63:0]             data;
        logic [ReqTidWidth-1:0]  tid;
    } req_t;

    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/l15_be_gen.sv
// l15_be_gen: store size/offset to byte enables and big-to-little-endian lane-shifted write data
module l15_be_gen
    import l15_resp_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_data,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata
);
    logic [7:0] w_mask;

    // lanes shifted past byte 7 fall off the 8-bit result
    assign w_mask  = (i_size >= 3'd3) ? 8'hFF : (i_size == 3'd2) ? 8'h0F : (i_size == 3'd1) ? 8'h03 : 8'h01;
    assign o_be    = w_mask << i_offset;
    assign o_wdata = bswap64(i_data) << {i_offset, 3'b000};
endmodule

// File: rtl/l15_mem_responder.sv
// l15_mem_responder: L1.5 request responder executing 64-bit beats on a grant/rvalid memory port
module l15_mem_responder
    import l15_resp_pkg::*;
#(
    parameter int unsigned AddrWidth = ReqAddrWidth,
    parameter int unsigned TidWidth  = ReqTidWidth,
    parameter int unsigned LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_val_i,
    input  logic [4:0]           req_rqtype_i,
    input  logic [2:0]           req_size_i,
    input  logic [AddrWidth-1:0] req_address_i,
    input  logic [63:0]          req_data_i,
    input  logic [TidWidth-1:0]  req_threadid_i,
    output logic                 req_header_ack_o,
    output logic                 rtn_val_o,
    output logic [3:0]           rtn_rtntype_o,
    output logic [TidWidth-1:0]  rtn_threadid_o,
    output logic [LineWidth-1:0] rtn_data_o,
    input  logic                 rtn_ack_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [63:0]          mem_wdata_o,
    output logic [7:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i
);
    localparam int unsigned NrBeats   = LineWidth / 64;
    localparam int unsigned BeatWidth = $clog2(NrBeats) + 1;
    localparam int unsigned IdxWidth  = (NrBeats > 1) ? $clog2(NrBeats) : 1;
    localparam int unsigned OffWidth  = $clog2(LineWidth / 8);

    state_e                      r_state, w_state_nxt;
    req_t                        r_req;
    logic [BeatWidth-1:0]        r_beat;
    logic [0:NrBeats-1][63:0]    r_line;
    logic [3:0]                  r_rtntype;
    logic                        w_accept, w_known, w_store, w_last;
    logic [AddrWidth-1:0]        w_line_base, w_beat_addr;
    logic [7:0]                  w_be;
    logic [63:0]                 w_wdata;

    // the ack is combinational on req_val_i, so reset must gate it to keep outputs at 0
    assign w_accept    = rst_ni && (r_state == S_IDLE) && req_val_i;
    assign w_known     = req_rqtype_i inside {RQ_LOAD, RQ_IMISS, RQ_STORE};
    assign w_store     = r_req.rqtype == RQ_STORE;
    assign w_last      = r_beat == BeatWidth'(NrBeats - 1);
    assign w_line_base = {req_address_i[AddrWidth-1:OffWidth], OffWidth'(0)};
    assign w_beat_addr = r_req.addr[AddrWidth-1:0] + AddrWidth'({r_beat, 3'b000});

    l15_be_gen u_be_gen (
        .i_size  (r_req.size),
        .i_offset(r_req.addr[2:0]),
        .i_data  (r_req.data),
        .o_be    (w_be),
        .o_wdata (w_wdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (req_val_i) w_state_nxt = w_known ? S_REQ : S_RESP;
            S_REQ:    if (mem_gnt_i) w_state_nxt = S_WAIT_R;
            S_WAIT_R: if (mem_rvalid_i) w_state_nxt = (w_store || w_last) ? S_RESP : S_REQ;
            S_RESP:   if (rtn_ack_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req     <= '0;
            r_beat    <= '0;
            r_line    <= '0;
            r_rtntype <= '0;
        end else if (w_accept) begin
            r_req     <= '{rqtype: req_rqtype_i,
                           size:   req_size_i,
                           addr:   ReqAddrWidth'((req_rqtype_i == RQ_STORE) ? req_address_i : w_line_base),
                           data:   req_data_i,
                           tid:    ReqTidWidth'(req_threadid_i)};
            r_beat    <= '0;
            r_line    <= '0;
            r_rtntype <= (req_rqtype_i == RQ_LOAD)  ? RT_LOAD :
                         (req_rqtype_i == RQ_IMISS) ? RT_IFILL :
                         (req_rqtype_i == RQ_STORE) ? RT_ST_ACK : RT_ERR;
        end else if (r_state == S_WAIT_R && mem_rvalid_i && !w_store) begin
            r_line[IdxWidth'(r_beat)] <= bswap64(mem_rdata_i);
            if (!w_last) r_beat <= r_beat + BeatWidth'(1);
        end
    end

    assign req_header_ack_o = w_accept;
    assign mem_req_o        = r_state == S_REQ;
    assign mem_we_o         = mem_req_o && w_store;
    assign mem_addr_o       = !mem_req_o ? '0 : w_store ? {r_req.addr[AddrWidth-1:3], 3'b000} : w_beat_addr;
    assign mem_be_o         = !mem_req_o ? '0 : w_store ? w_be : 8'hFF;
    assign mem_wdata_o      = mem_we_o ? w_wdata : '0;
    assign rtn_val_o        = r_state == S_RESP;
    assign rtn_rtntype_o    = r_rtntype;
    assign rtn_threadid_o   = r_req.tid[TidWidth-1:0];
    assign rtn_data_o       = r_line;
endmodule

// File: tb/tb_l15_mem_responder.sv
// tb_l15_mem_responder: scoreboard bench with a grant/rvalid memory model and directed L1.5 requests
module tb_l15_mem_responder;
    import l15_resp_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_val_i;
    logic [4:0]   req_rqtype_i;
    logic [2:0]   req_size_i;
    logic [39:0]  req_address_i;
    logic [63:0]  req_data_i;
    logic [1:0]   req_threadid_i;
    logic         req_header_ack_o;
    logic         rtn_val_o;
    logic [3:0]   rtn_rtntype_o;
    logic [1:0]   rtn_threadid_o;
    logic [127:0] rtn_data_o;
    logic         rtn_ack_i;
    logic         mem_req_o;
    logic         mem_gnt_i;
    logic         mem_we_o;
    logic [39:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o;
    logic [7:0]   mem_be_o;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;

    always #5 clk_i = ~clk_i;

    l15_mem_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i), .req_size_i(req_size_i),
        .req_address_i(req_address_i), .req_data_i(req_data_i), .req_threadid_i(req_threadid_i),
        .req_header_ack_o(req_header_ack_o),
        .rtn_val_o(rtn_val_o), .rtn_rtntype_o(rtn_rtntype_o), .rtn_threadid_o(rtn_threadid_o),
        .rtn_data_o(rtn_data_o), .rtn_ack_i(rtn_ack_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct { logic we; logic [39:0] addr; logic [7:0] be; logic [63:0] wdata; } mexp_t;
    typedef struct { logic [3:0] typ; logic [1:0] tid; logic [127:0] data; } rexp_t;

    mexp_t       mq[$];
    rexp_t       rq[$];
    logic [63:0] rdq[$];
    int          checks = 0;
    int          errors = 0;
    int          gnt_delay = 1;
    int          ack_cnt = 0;
    bit          suppress = 1'b0;
    bit          inject = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // memory model: grant after gnt_delay request cycles, rvalid the cycle after grant
    initial begin
        int cnt;
        cnt = 0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #2;
            if (!rst_ni) begin
                cnt = 0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            end else begin
                mem_rvalid_i = (mem_gnt_i && !suppress) || inject;
                mem_rdata_i  = '0;
                if (inject) mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
                else if (mem_rvalid_i && rdq.size() > 0) mem_rdata_i = rdq.pop_front();
                inject = 1'b0;
                if (mem_req_o) begin
                    mem_gnt_i = (cnt >= gnt_delay);
                    cnt = mem_gnt_i ? 0 : cnt + 1;
                end else begin
                    mem_gnt_i = 1'b0; cnt = 0;
                end
            end
        end
    end

    // monitors: memory beats and responses compared against queued expectations every cycle they are presented
    initial forever begin
        @(negedge clk_i);
        if (req_header_ack_o) ack_cnt++;
        if (rst_ni && mem_req_o) begin
            if (mq.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_unexpected actual_addr=%0h expected=none", mem_addr_o);
            end else begin
                chk("mem_we", mem_we_o, mq[0].we);
                chk("mem_addr", mem_addr_o, mq[0].addr);
                chk("mem_be", mem_be_o, mq[0].be);
                chk("mem_wdata", mem_wdata_o, mq[0].wdata);
                if (mem_gnt_i) void'(mq.pop_front());
            end
        end
        if (rtn_val_o) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL rtn_unexpected actual_type=%0d expected=none", rtn_rtntype_o);
            end else begin
                chk("rtn_type", rtn_rtntype_o, rq[0].typ);
                chk("rtn_tid", rtn_threadid_o, rq[0].tid);
                chk("rtn_data", rtn_data_o, rq[0].data);
                if (rtn_ack_i) void'(rq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i); #1;
    endtask

    task automatic issue(input logic [4:0] t, input logic [2:0] s, input logic [39:0] a,
                         input logic [63:0] d, input logic [1:0] tid);
        tick;
        req_val_i = 1'b1; req_rqtype_i = t; req_size_i = s;
        req_address_i = a; req_data_i = d; req_threadid_i = tid;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (req_header_ack_o) break;
        end
        chk("header_ack", req_header_ack_o, 1'b1);
        tick;
        req_val_i = 1'b0;
    endtask

    task automatic drain;
        for (int n = 0; n < 300; n++) begin
            if (rq.size() == 0 && mq.size() == 0) break;
            tick;
        end
        chk("drain_pending", rq.size() + mq.size(), 0);
    endtask

    task automatic check_zero(input string t);
        chk({t, "_hdr_ack"}, req_header_ack_o, 0);
        chk({t, "_rtn_val"}, rtn_val_o, 0);
        chk({t, "_rtn_type"}, rtn_rtntype_o, 0);
        chk({t, "_rtn_tid"}, rtn_threadid_o, 0);
        chk({t, "_rtn_data"}, rtn_data_o, 0);
        chk({t, "_mem_req"}, mem_req_o, 0);
        chk({t, "_mem_we"}, mem_we_o, 0);
        chk({t, "_mem_addr"}, mem_addr_o, 0);
        chk({t, "_mem_be"}, mem_be_o, 0);
        chk({t, "_mem_wdata"}, mem_wdata_o, 0);
    endtask

    initial begin
        int base;
        rst_ni = 1'b0; req_val_i = 1'b1; req_rqtype_i = RQ_LOAD; req_size_i = '0;
        req_address_i = '0; req_data_i = '0; req_threadid_i = '0; rtn_ack_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_zero("reset");
        tick;
        req_val_i = 1'b0; rst_ni = 1'b1;

        mq.push_back('{1'b0, 40'h80000010, 8'hFF, 64'h0});
        mq.push_back('{1'b0, 40'h80000018, 8'hFF, 64'h0});
        rdq.push_back(64'h0011223344556677);
        rdq.push_back(64'h8899AABBCCDDEEFF);
        rq.push_back('{RT_LOAD, 2'd2, 128'h7766554433221100_FFEEDDCCBBAA9988});
        issue(RQ_LOAD, 3'd0, 40'h80000018, 64'h0, 2'd2);
        drain;

        mq.push_back('{1'b1, 40'h1000, 8'hC0, 64'hCDAB000000000000});
        rq.push_back('{RT_ST_ACK, 2'd1, 128'h0});
        issue(RQ_STORE, 3'd1, 40'h1006, 64'hABCD000000000000, 2'd1);
        drain;

        gnt_delay = 5;
        mq.push_back('{1'b0, 40'h2000, 8'hFF, 64'h0});
        mq.push_back('{1'b0, 40'h2008, 8'hFF, 64'h0});
        rdq.push_back(64'h0102030405060708);
        rdq.push_back(64'h1112131415161718);
        rq.push_back('{RT_IFILL, 2'd3, 128'h0807060504030201_1817161514131211});
        issue(RQ_IMISS, 3'd0, 40'h2008, 64'h0, 2'd3);
        drain;
        gnt_delay = 1;

        rq.push_back('{RT_ERR, 2'd0, 128'h0});
        issue(5'd7, 3'd0, 40'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
        @(negedge clk_i);
        chk("err_rtn_next_cycle", rtn_val_o, 1'b1);
        drain;

        mq.push_back('{1'b1, 40'h4000, 8'hC0, 64'hBBAA000000000000});
        rq.push_back('{RT_ST_ACK, 2'd0, 128'h0});
        issue(RQ_STORE, 3'd2, 40'h4006, 64'hAABBCCDD00000000, 2'd0);
        drain;

        rtn_ack_i = 1'b0;
        mq.push_back('{1'b1, 40'h3000, 8'hFF, 64'h0807060504030201});
        rq.push_back('{RT_ST_ACK, 2'd2, 128'h0});
        rq.push_back('{RT_ERR, 2'd1, 128'h0});
        issue(RQ_STORE, 3'd3, 40'h3000, 64'h0102030405060708, 2'd2);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (rtn_val_o) break;
        end
        chk("hold_rtn_val", rtn_val_o, 1'b1);
        tick;
        base = ack_cnt;
        req_val_i = 1'b1; req_rqtype_i = 5'd7; req_threadid_i = 2'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("hold_no_ack", req_header_ack_o, 1'b0);
            tick;
        end
        rtn_ack_i = 1'b1;
        @(negedge clk_i);
        chk("ack_cycle_no_hdr_ack", req_header_ack_o, 1'b0);
        tick;
        @(negedge clk_i);
        chk("hdr_ack_after_rtn_ack", req_header_ack_o, 1'b1);
        tick;
        req_val_i = 1'b0;
        chk("hold_ack_count", ack_cnt - base, 1);
        drain;

        suppress = 1'b1;
        mq.push_back('{1'b0, 40'h5000, 8'hFF, 64'h0});
        issue(RQ_LOAD, 3'd0, 40'h5000, 64'h0, 2'd1);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (mem_req_o && mem_gnt_i) break;
        end
        tick;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_zero("midrst");
        tick;
        rst_ni = 1'b1; inject = 1'b1; suppress = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("abort_no_rtn", rtn_val_o, 1'b0);
        end
        chk("abort_mem_queue", mq.size(), 0);

        mq.push_back('{1'b0, 40'h6010, 8'hFF, 64'h0});
        mq.push_back('{1'b0, 40'h6018, 8'hFF, 64'h0});
        rdq.push_back(64'hFFEEDDCCBBAA9988);
        rdq.push_back(64'h0706050403020100);
        rq.push_back('{RT_LOAD, 2'd3, 128'h8899AABBCCDDEEFF_0001020304050607});
        issue(RQ_LOAD, 3'd0, 40'h6010, 64'h0, 2'd3);
        drain;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l15_mem_responder.md
Name: l15_mem_responder

Overview:
- Responder end of the L1.5 NoC request/response interface used by the write-through data cache and the instruction cache adapter when the NoC type is L15 big-endian.
- Accepts one L1.5 request at a time: load, instruction fill or store.
- Executes the request as 64-bit beats on a simple grant/rvalid SRAM-style memory port, then returns an L1.5-style response with big-endian byte ordering.
- Used as the memory-side model/bridge for standalone core integration and for verifying the L1.5 adapter without a full L1.5/L2.

Parameters:
- AddrWidth, 40, physical request address width.
- TidWidth, 2, thread/transaction id width echoed in responses.
- LineWidth, 128, cache line width in bits returned for load/ifill; must be a multiple of 64.
- NrBeats, LineWidth/64, derived memory beats per line; not user-set.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_val_i  in  1  L1.5 request valid.
- req_rqtype_i  in  5  request type: LOAD=0, IMISS=16, STORE=1; any other value is unsupported.
- req_size_i  in  3  store size: 0=1B, 1=2B, 2=4B, 3=8B.
- req_address_i  in  AddrWidth  byte address.
- req_data_i  in  64  store data, big-endian byte lane order.
- req_threadid_i  in  TidWidth  transaction id.
- req_header_ack_o  out  1  one-cycle accept pulse.
- rtn_val_o  out  1  response valid.
- rtn_rtntype_o  out  4  LOAD_RET=0, IFILL_RET=1, ST_ACK=4, ERR=15.
- rtn_threadid_o  out  TidWidth  echoed id.
- rtn_data_o  out  LineWidth  line data, beat 0 in the most significant 64 bits, bytes big-endian.
- rtn_ack_i  in  1  response consumed.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  AddrWidth  8B-aligned beat address.
- mem_wdata_o  out  64  little-endian write data.
- mem_be_o  out  8  byte enables.
- mem_rvalid_i  in  1  read data valid; arrives one or more cycles after grant, in order.
- mem_rdata_i  in  64  little-endian read data.

Behaviour:
- Reset values: every output is 0; FSM is IDLE; beat counter is 0; captured request registers are 0.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - When req_val_i=1, pulse req_header_ack_o for exactly that cycle.
  - Capture rqtype, size, address, data and threadid.
  - LOAD/IMISS: line-align the address (clear the low log2(LineWidth/8) bits), clear the beat counter, go to REQ.
  - STORE: go to REQ.
  - Unsupported type: build an ERR response with data 0 and go to RESP.
- REQ:
  - Hold mem_req_o=1 with stable address, we, be and wdata until mem_gnt_i=1, then go to WAIT_R.
  - Store beat: address = captured address & ~7.
  - Store byte enables: ((1<<(1<<size))-1) << address[2:0], masked to 8 bits. A misaligned size that overflows the word drops the out-of-range lanes; no error is raised.
  - Store data: byte-reverse req_data within the 64-bit word, then shift left by 8*address[2:0].
  - Load beats: address = line base + 8*beat, be=8'hFF, we=0.
- WAIT_R:
  - On mem_rvalid_i, byte-reverse mem_rdata_i and write it into line slot beat.
  - Load with beat<NrBeats-1: increment beat, go back to REQ.
  - Last load beat: go to RESP.
  - Store: write data is discarded; build ST_ACK with data 0; go to RESP.
- RESP:
  - rtn_val_o=1 while in RESP; rtntype, threadid and data are held stable.
  - When rtn_ack_i=1 in the same cycle, rtn_val_o drops to 0 in the next cycle and the FSM returns to IDLE.
  - A new request is not acked in the ack cycle; earliest header ack is the cycle after.
- Single outstanding request: req_header_ack_o is 0 in every state except IDLE.
- Load/IMISS latency with grant and rvalid each one cycle after request:
  - ack at cycle 0, first mem_req at cycle 1, rtn_val at cycle 1+3*NrBeats.
- Store latency: ack at cycle 0, mem_req at cycle 1, rtn_val at cycle 4.
- The beat counter is log2(NrBeats)+1 bits wide and never wraps within a line.
- Asynchronous reset mid-transaction:
  - All outputs clear immediately.
  - Any late mem_rvalid_i arriving after reset deassertion is ignored while in IDLE or REQ.
  - No response is produced for the aborted request.

Decomposition:
- Shared package l15_resp_pkg holds:
  - rqtype/rtntype localparams.
  - State enum.
  - Request capture struct {rqtype, size, addr, data, tid}.
  - Byte-reverse function.
- One sub-module, l15_be_gen: combinational size/offset to byte-enable and data shifter.
- The FSM and line buffer live in the top.

Test Plan:
- LOAD, addr 0x80000018, tid 2; memory returns 0x0011223344556677 then 0x8899AABBCCDDEEFF:
  - mem addrs 0x80000010 then 0x80000018.
  - rtn_rtntype=0, tid=2.
  - rtn_data=0x7766554433221100_FFEEDDCCBBAA9988.
- STORE, size=1, addr 0x1006, data 0xABCD000000000000:
  - mem_be=8'hC0, mem_addr=0x1000, mem_wdata=0xCDAB000000000000.
  - ST_ACK returned with tid echoed.
- IMISS with mem_gnt_i held low for 5 cycles:
  - mem_req_o, address and be stay stable all 5 cycles.
  - rtntype=1 returned after both beats.
- rqtype=7:
  - No mem_req_o.
  - rtn_rtntype=15, data 0, rtn_val on the cycle after the ack.
- rtn_ack_i held low 4 cycles while req_val_i=1:
  - Response held stable.
  - Exactly one header ack, occurring the cycle after the rtn_ack_i cycle.
- rst_ni pulsed low in WAIT_R, with rvalid arriving after release:
  - All outputs 0.
  - No rtn_val.
  - Next LOAD completes normally.
